// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command constants and timing helper
//
// Contents:
//   ps2_state_e    host transmitter FSM state encoding
//   CMD_*          common keyboard command bytes
//   us_to_cycles   converts a microsecond interval to system clock cycles

package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // 64-bit intermediate so that e.g. 100 MHz * 15000 us does not overflow.
    function automatic int us_to_cycles(input int clk_hz, input int us);
        longint cyc;
        cyc = (longint'(clk_hz) * longint'(us)) / longint'(1_000_000);
        return int'(cyc);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchroniser, glitch filter and falling-edge strobe
//
// Ports:
//   clk_i     system clock
//   resetn_i  synchronous active-low reset
//   line_i    raw asynchronous pin level
//   level_o   filtered level (changes after FILTER_LEN consecutive equal samples)
//   fall_o    one-cycle strobe when level_o goes 1 -> 0

module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // Idle PS/2 lines are pulled high, so everything resets to the high level.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            fall_q <= 1'b0;
            // cnt_q counts consecutive samples that disagree with the accepted
            // level; any agreeing sample restarts the count.
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync_q;
                fall_q  <= ~sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
//
// Ports:
//   clk, reset               system clock, synchronous active-low reset
//   tx_data, tx_valid        command byte request, accepted when tx_ready
//   tx_ready                 high only while idle
//   tx_done / tx_err         one-cycle result pulses (device ACK / timeout or no ACK)
//   rx_inhibit               high while a transmission is in progress
//   ps2_clk_i, ps2_data_i    raw pin levels
//   ps2_clk_oe, ps2_data_oe  pull-low enables for the open-drain pins

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int START_TO_US = 15000,
    parameter int FRAME_TO_US = 2000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INHIBIT_CYC = us_to_cycles(CLK_FREQ, INHIBIT_US);
    localparam int START_CYC   = us_to_cycles(CLK_FREQ, START_TO_US);
    localparam int FRAME_CYC   = us_to_cycles(CLK_FREQ, FRAME_TO_US);
    localparam int MAX_AB      = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int MAX_CYC     = (MAX_AB > FRAME_CYC) ? MAX_AB : FRAME_CYC;
    // Timer is loaded with (count - 1) and counts down to zero.
    localparam int TW          = $clog2(MAX_CYC);

    ps2_state_e    state_q, state_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          data_meta_q, data_s_q;
    logic          clk_level;
    logic          clk_fall;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk_i   (clk),
        .resetn_i(reset),
        .line_i  (ps2_clk_i),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            timer_q     <= '0;
            ack_q       <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_meta_q <= 1'b1;
            data_s_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            timer_q     <= timer_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            err_q       <= err_d;
            data_meta_q <= ps2_data_i;
            data_s_q    <= data_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        timer_d     = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        ack_d       = ack_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_d   = {~^tx_data, tx_data};
                    bit_cnt_d = '0;
                    timer_d   = TW'(INHIBIT_CYC - 1);
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timer_q == '0) begin
                    ps2_data_oe = 1'b1;
                    timer_d     = TW'(START_CYC - 1);
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                ps2_data_oe = 1'b1;
                if (clk_fall) begin
                    timer_d = TW'(FRAME_CYC - 1);
                    state_d = ST_DATA;
                end else if (timer_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                ps2_data_oe = ~shift_q[0];
                if (clk_fall) begin
                    shift_d   = {1'b1, shift_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                ps2_data_oe = ~shift_q[0];
                if (clk_fall) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // The device's ACK is the data level at the 11th falling edge;
                // it is captured here and judged in ACK.
                if (clk_fall) begin
                    ack_d   = data_s_q;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!ack_q) begin
                    state_d = ST_WAIT_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_level && data_s_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame watchdog spans first falling edge through bus-idle; it wins
        // over any other outcome so done and err can never coincide.
        if ((state_q inside {ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAIT_IDLE})
            && (timer_q == '0)) begin
            state_d     = ST_IDLE;
            done_d      = 1'b0;
            err_d       = 1'b1;
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
        end
    end

    assign tx_ready   = (state_q == ST_IDLE);
    assign rx_inhibit = (state_q != ST_IDLE);
    assign tx_done    = done_q;
    assign tx_err     = err_q;

endmodule
